// File: rtl/fase_sequencer.sv
// fase_sequencer: multi-cycle control FSM for the Fase datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB, stalls on memReady, counts retirements.
module fase_sequencer #(
  parameter int              OP_W    = 6,
  parameter int              CNT_W   = 8,
  parameter logic [OP_W-1:0] HALT_OP = '1
) (
  input  logic             clkFase,
  input  logic             rstnFase,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             irWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic             memToReg,
  output logic [1:0]       aluOp,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] instrCount
);

  localparam logic [OP_W-1:0] OP_R  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW = OP_W'(6'b101011);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_R,
    C_LW,
    C_SW
  } cls_t;

  state_t state;
  state_t nxt;
  cls_t   cls;
  cls_t   dec_cls;
  logic   dec_ok;
  logic   set_err;
  logic   clr_err;
  logic   retire;

  // State, latched class, sticky error and retire counter.
  always_ff @(posedge clkFase) begin
    if (!rstnFase) begin
      state      <= S_IDLE;
      cls        <= C_R;
      err        <= 1'b0;
      instrCount <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls <= dec_cls;
      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (retire) instrCount <= instrCount + CNT_W'(1);
    end
  end

  // Opcode class decode; only consumed while in DECODE.
  always_comb begin
    dec_cls = cls;
    dec_ok  = 1'b0;
    unique case (1'b1)
      (opcode == OP_R):  begin dec_cls = C_R;  dec_ok = 1'b1; end
      (opcode == OP_LW): begin dec_cls = C_LW; dec_ok = 1'b1; end
      (opcode == OP_SW): begin dec_cls = C_SW; dec_ok = 1'b1; end
      default: ;
    endcase
  end

  // Next state and per-stage enables.
  always_comb begin
    nxt      = state;
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    regWrite = 1'b0;
    memToReg = 1'b0;
    aluOp    = 2'b00;
    done     = 1'b0;
    set_err  = 1'b0;
    clr_err  = 1'b0;
    retire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) nxt = S_FETCH;
      end
      S_FETCH: begin
        memRead = 1'b1;
        if (memReady) begin
          pcWrite = 1'b1;
          irWrite = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          nxt = S_EXEC;
        end else begin
          nxt     = S_DONE;
          set_err = (opcode != HALT_OP);
        end
      end
      S_EXEC: begin
        if (cls == C_R) begin
          aluOp = 2'b10;
          nxt   = S_WB;
        end else begin
          nxt = S_MEM;
        end
      end
      S_MEM: begin
        memRead  = (cls == C_LW);
        memWrite = (cls == C_SW);
        if (memReady) begin
          if (cls == C_SW) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        memToReg = (cls == C_LW);
        retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) begin
          nxt     = S_IDLE;
          clr_err = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_fase_sequencer.sv
// tb_fase_sequencer: per-cycle expected traces built from instruction
// plans (opcode, stall counts), applied from a record table.
module tb_fase_sequencer;

  logic       clkFase = 1'b0;
  logic       rstnFase = 1'b0;
  logic       start = 1'b0;
  logic [5:0] opcode = '0;
  logic       memReady = 1'b0;
  logic       pcWrite, irWrite, memRead, memWrite;
  logic       regWrite, memToReg, busy, done, err;
  logic [1:0] aluOp;
  logic [7:0] instrCount;
  logic [10:0] outs;

  fase_sequencer dut (
    .clkFase(clkFase), .rstnFase(rstnFase),
    .start(start), .opcode(opcode),
    .memReady(memReady),
    .pcWrite(pcWrite), .irWrite(irWrite),
    .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .memToReg(memToReg),
    .aluOp(aluOp), .busy(busy), .done(done),
    .err(err), .instrCount(instrCount)
  );

  always #5 clkFase = ~clkFase;

  assign outs = {pcWrite, irWrite, memRead, memWrite,
                 regWrite, memToReg, aluOp, busy, done, err};

  // {pcW,irW,mRd,mWr,rW,m2r,alu[1:0],busy,done,err}
  localparam logic [10:0] IDLE     = 11'b00000000000;
  localparam logic [10:0] F_STALL  = 11'b00100000100;
  localparam logic [10:0] F_GO     = 11'b11100000100;
  localparam logic [10:0] DEC      = 11'b00000000100;
  localparam logic [10:0] EX_R     = 11'b00000010100;
  localparam logic [10:0] EX_M     = 11'b00000000100;
  localparam logic [10:0] MEM_LW   = 11'b00100000100;
  localparam logic [10:0] MEM_SW   = 11'b00010000100;
  localparam logic [10:0] WB_R     = 11'b00001000100;
  localparam logic [10:0] WB_LW    = 11'b00001100100;
  localparam logic [10:0] DONE_OK  = 11'b00000000010;
  localparam logic [10:0] DONE_ERR = 11'b00000000011;

  typedef struct {
    logic        rstn;
    logic        st;
    logic [5:0]  op;
    logic        rdy;
    logic        chk;
    logic [10:0] ev;
    logic [7:0]  ec;
  } vec_t;

  vec_t       q[$];
  logic [7:0] cnt = '0;
  logic [5:0] ops[3];
  int         total = 0;
  int         passed = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  task automatic push(input logic rstn, input logic st,
                      input logic [5:0] op, input logic rdy,
                      input logic [10:0] ev);
    vec_t v;
    v.rstn = rstn; v.st = st; v.op = op; v.rdy = rdy;
    v.chk = 1'b1; v.ev = ev; v.ec = cnt;
    q.push_back(v);
  endtask

  task automatic run_start();
    push(1, 1, junk(), rb(), IDLE);
  endtask

  // k: 0 = R-type, 1 = LW, 2 = SW
  task automatic instr(input int k, input int fs, input int ms);
    for (int i = 0; i < fs; i++) push(1, rb(), junk(), 0, F_STALL);
    push(1, rb(), junk(), 1, F_GO);
    push(1, rb(), ops[k], rb(), DEC);
    push(1, rb(), junk(), rb(), (k == 0) ? EX_R : EX_M);
    if (k == 0) begin
      push(1, rb(), junk(), rb(), WB_R);
    end else if (k == 1) begin
      for (int i = 0; i < ms; i++) push(1, rb(), junk(), 0, MEM_LW);
      push(1, rb(), junk(), 1, MEM_LW);
      push(1, rb(), junk(), rb(), WB_LW);
    end else begin
      for (int i = 0; i < ms; i++) push(1, rb(), junk(), 0, MEM_SW);
      push(1, rb(), junk(), 1, MEM_SW);
    end
    cnt = cnt + 8'd1;
  endtask

  task automatic finish_run(input logic [5:0] op, input logic is_err);
    logic [10:0] ev;
    ev = is_err ? DONE_ERR : DONE_OK;
    push(1, rb(), junk(), 1, F_GO);
    push(1, rb(), op, rb(), DEC);
    push(1, 1, junk(), rb(), ev);
    push(1, 1, junk(), rb(), ev);
    push(1, 0, junk(), rb(), ev);
    push(1, 0, junk(), rb(), IDLE);
    push(1, 0, junk(), rb(), IDLE);
  endtask

  task automatic do_reset();
    vec_t v;
    v.rstn = 0; v.st = 0; v.op = '0; v.rdy = 0;
    v.chk = 0; v.ev = IDLE; v.ec = '0;
    q.push_back(v);
    q.push_back(v);
    cnt = '0;
    push(1, 0, junk(), 1, IDLE);
  endtask

  initial begin
    int k;
    ops[0] = 6'b000000;
    ops[1] = 6'b100011;
    ops[2] = 6'b101011;

    do_reset();
    push(1, 0, junk(), rb(), IDLE);
    // R-type, LW with fetch/mem stalls, SW, then halt
    run_start();
    instr(0, 0, 0);
    instr(1, 3, 2);
    instr(2, 0, 0);
    finish_run(6'b111111, 1'b0);
    // two R-types then halt: count 2, err 0
    do_reset();
    run_start();
    instr(0, 0, 0);
    instr(0, 1, 0);
    finish_run(6'b111111, 1'b0);
    // illegal opcode keeps count, sets err until DONE exits
    run_start();
    finish_run(6'b000101, 1'b1);
    // reset during an LW MEM stall
    run_start();
    push(1, 0, junk(), 1, F_GO);
    push(1, 0, ops[1], 1, DEC);
    push(1, 0, junk(), 1, EX_M);
    push(1, 0, junk(), 0, MEM_LW);
    push(0, 0, junk(), 0, MEM_LW);
    cnt = '0;
    push(1, 0, junk(), 1, IDLE);
    push(1, 0, junk(), 1, IDLE);
    // random program long enough to wrap the counter
    run_start();
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(2, 0);
      instr(k, $urandom_range(2, 0), $urandom_range(2, 0));
    end
    finish_run(6'b111111, 1'b0);
    run_start();
    instr(1, 0, 1);
    finish_run(6'($urandom_range(62, 44)), 1'b1);

    foreach (q[i]) begin
      @(negedge clkFase);
      rstnFase = q[i].rstn;
      start    = q[i].st;
      opcode   = q[i].op;
      memReady = q[i].rdy;
      #1;
      if (q[i].chk) begin
        total++;
        if (outs === q[i].ev) passed++;
        else $display("FAIL outs step %0d: got %b want %b",
                      i, outs, q[i].ev);
        total++;
        if (instrCount === q[i].ec) passed++;
        else $display("FAIL instrCount step %0d: got %0d want %0d",
                      i, instrCount, q[i].ec);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
